mdu_issue_sched: RTL and testbench



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_wb_resv.sv | 90 +++++++++
 rtl/mdu_issue_sched.sv | 90 +++++++++
 tb/tb_mdu_issue_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and default latencies for the multiply/divide unit issue and writeback path.
package mdu_pkg;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 20;
    localparam int MDU_ROB_ID_W = 6;
    // Tag storage width; ROB_ID_W of any instance must not exceed it.
    localparam int MDU_ROB_ID_MAX_W = 16;

    typedef enum logic {
        MDU_MUL = 1'b0,
        MDU_DIV = 1'b1
    } MduSrc;

    typedef struct packed {
        logic                        valid;
        logic                        is_lo;
        logic                        is_div;
        logic [MDU_ROB_ID_MAX_W-1:0] rob_id;
    } MduWbTag;

endpackage

// File: rtl/mdu_wb_resv.sv
// Write-port reservation vector and the tag pipeline that travels with it;
// res[k] set means the MDU write port is taken k cycles from now.
module mdu_wb_resv
    import mdu_pkg::*;
#(
    parameter int MUL_LAT  = MDU_MUL_LAT,
    parameter int DIV_LAT  = MDU_DIV_LAT,
    parameter int ROB_ID_W = MDU_ROB_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    output logic                mulFree,
    output logic                divFree,
    input  logic                claim,
    input  MduSrc               claimSrc,
    input  logic [ROB_ID_W-1:0] claimHiId,
    input  logic [ROB_ID_W-1:0] claimLoId,
    output logic                wbValid,
    output logic                wbIsLo,
    output logic                wbIsDiv,
    output logic [ROB_ID_W-1:0] wbRobId,
    output logic                idle
);

    localparam int DEPTH = DIV_LAT + 2;

    logic [DEPTH-1:0] res;
    logic [DEPTH-1:0] resNext;
    MduWbTag          tagQ    [DEPTH];
    MduWbTag          tagNext [DEPTH];
    MduWbTag          hiTag;
    MduWbTag          loTag;

    // A pair needs both its HI slot (L) and LO slot (L+1) free.
    assign mulFree = ~res[MUL_LAT] & ~res[MUL_LAT+1];
    assign divFree = ~res[DIV_LAT] & ~res[DIV_LAT+1];

    always_comb begin
        hiTag = '0;
        hiTag.valid = 1'b1;
        hiTag.is_div = (claimSrc == MDU_DIV);
        hiTag.rob_id[ROB_ID_W-1:0] = claimHiId;
        loTag = '0;
        loTag.valid = 1'b1;
        loTag.is_lo = 1'b1;
        loTag.is_div = (claimSrc == MDU_DIV);
        loTag.rob_id[ROB_ID_W-1:0] = claimLoId;

        resNext = res >> 1;
        for (int k = 0; k < DEPTH - 1; k++) begin
            tagNext[k] = tagQ[k+1];
        end
        tagNext[DEPTH-1] = '0;

        // Slots land one below L because the whole vector shifts on the same edge.
        if (claim) begin
            if (claimSrc == MDU_DIV) begin
                resNext[DIV_LAT-1 +: 2] = 2'b11;
                tagNext[DIV_LAT-1] = hiTag;
                tagNext[DIV_LAT] = loTag;
            end else begin
                resNext[MUL_LAT-1 +: 2] = 2'b11;
                tagNext[MUL_LAT-1] = hiTag;
                tagNext[MUL_LAT] = loTag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            res <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tagQ[k] <= '0;
            end
        end else begin
            res <= resNext;
            for (int k = 0; k < DEPTH; k++) begin
                tagQ[k] <= tagNext[k];
            end
        end
    end

    assign wbValid = tagQ[0].valid;
    assign wbIsLo  = tagQ[0].is_lo;
    assign wbIsDiv = tagQ[0].is_div;
    assign wbRobId = tagQ[0].rob_id[ROB_ID_W-1:0];
    assign idle    = (res == '0);

endmodule

// File: rtl/mdu_issue_sched.sv
// Issue scheduler for the shared MDU: round-robin between the multiply and divide
// queues, launching a HI/LO pair only when its two writeback slots are free.
module mdu_issue_sched
    import mdu_pkg::*;
#(
    parameter int MUL_LAT  = MDU_MUL_LAT,
    parameter int DIV_LAT  = MDU_DIV_LAT,
    parameter int ROB_ID_W = MDU_ROB_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                mul_valid,
    output logic                mul_ready,
    input  logic [ROB_ID_W-1:0] mul_hi_id,
    input  logic [ROB_ID_W-1:0] mul_lo_id,
    input  logic                div_valid,
    output logic                div_ready,
    input  logic [ROB_ID_W-1:0] div_hi_id,
    input  logic [ROB_ID_W-1:0] div_lo_id,
    output logic                issue_valid,
    output logic                issue_is_div,
    output logic                wb_valid,
    output logic                wb_is_lo,
    output logic                wb_is_div,
    output logic [ROB_ID_W-1:0] wb_rob_id,
    output logic                idle
);

    // Handshake: a pair transfers in any cycle where valid && ready. Ready is
    // combinational from valid and the reservation state; the queue must hold an
    // unaccepted pair (valid and ids) stable until it sees ready.

    MduSrc prio;
    MduSrc claimSrc;
    logic  mulFree;
    logic  divFree;
    logic  mulOk;
    logic  divOk;
    logic  grantMul;
    logic  grantDiv;
    logic  open;

    always_comb begin
        mulOk    = mul_valid & mulFree;
        divOk    = div_valid & divFree;
        grantMul = mulOk & (~divOk | (prio == MDU_MUL));
        grantDiv = divOk & ~grantMul;
        open     = ~flush & ~rst;
    end

    assign mul_ready    = grantMul & open;
    assign div_ready    = grantDiv & open;
    assign issue_valid  = mul_ready | div_ready;
    assign issue_is_div = div_ready;
    assign claimSrc     = div_ready ? MDU_DIV : MDU_MUL;

    // prio names the source that wins a tie; it moves away from whoever was just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= MDU_MUL;
        end else if (mul_ready) begin
            prio <= MDU_DIV;
        end else if (div_ready) begin
            prio <= MDU_MUL;
        end
    end

    mdu_wb_resv #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .ROB_ID_W(ROB_ID_W)
    ) uResv (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .mulFree  (mulFree),
        .divFree  (divFree),
        .claim    (issue_valid),
        .claimSrc (claimSrc),
        .claimHiId(div_ready ? div_hi_id : mul_hi_id),
        .claimLoId(div_ready ? div_lo_id : mul_lo_id),
        .wbValid  (wb_valid),
        .wbIsLo   (wb_is_lo),
        .wbIsDiv  (wb_is_div),
        .wbRobId  (wb_rob_id),
        .idle     (idle)
    );

endmodule

// File: tb/tb_mdu_issue_sched.sv
// Bench for mdu_issue_sched: reset checks, single-cycle grant table, the multi-cycle
// scenarios, and a randomized run against a slot-calendar reference model.
module tb_mdu_issue_sched;

    localparam int MUL_LAT  = 5;
    localparam int DIV_LAT  = 20;
    localparam int ROB_ID_W = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                mul_valid;
    logic                mul_ready;
    logic [ROB_ID_W-1:0] mul_hi_id;
    logic [ROB_ID_W-1:0] mul_lo_id;
    logic                div_valid;
    logic                div_ready;
    logic [ROB_ID_W-1:0] div_hi_id;
    logic [ROB_ID_W-1:0] div_lo_id;
    logic                issue_valid;
    logic                issue_is_div;
    logic                wb_valid;
    logic                wb_is_lo;
    logic                wb_is_div;
    logic [ROB_ID_W-1:0] wb_rob_id;
    logic                idle;

    mdu_issue_sched #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .ROB_ID_W(ROB_ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .mul_valid   (mul_valid),
        .mul_ready   (mul_ready),
        .mul_hi_id   (mul_hi_id),
        .mul_lo_id   (mul_lo_id),
        .div_valid   (div_valid),
        .div_ready   (div_ready),
        .div_hi_id   (div_hi_id),
        .div_lo_id   (div_lo_id),
        .issue_valid (issue_valid),
        .issue_is_div(issue_is_div),
        .wb_valid    (wb_valid),
        .wb_is_lo    (wb_is_lo),
        .wb_is_div   (wb_is_div),
        .wb_rob_id   (wb_rob_id),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        int pre;     // 0 = fresh, 1 = a mul accepted the cycle before, 2 = a div accepted
        bit mv;
        bit dv;
        bit fl;
        bit rs;
        bit expMr;
        bit expDr;
        bit expIdle;
    } VecT;
    VecT vecs [12];

    typedef struct {
        bit lo;
        bit isDiv;
        int id;
    } WbEnt;
    WbEnt sched [int];   // absolute cycle -> result expected on the write port
    int   t;
    bit   lastWasMul;
    bit   mFree, dFree, blocked, mAcc, dAcc;
    bit   expWbV;
    WbEnt e;
    logic [ROB_ID_W-1:0] s2Ids [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkWb(input string name, input bit v, input bit lo, input bit dv, input int id);
        chk({name, " wb_valid"}, wb_valid, v);
        if (v) begin
            chk({name, " wb_is_lo"}, wb_is_lo, lo);
            chk({name, " wb_is_div"}, wb_is_div, dv);
            chk({name, " wb_rob_id"}, wb_rob_id, id);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        flush = 0;
        mul_valid = 0;
        div_valid = 0;
        mul_hi_id = 0;
        mul_lo_id = 0;
        div_hi_id = 0;
        div_lo_id = 0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        vecs[0]  = '{0, 1, 0, 0, 0, 1, 0, 1};
        vecs[1]  = '{0, 0, 1, 0, 0, 0, 1, 1};
        vecs[2]  = '{0, 1, 1, 0, 0, 1, 0, 1};
        vecs[3]  = '{0, 1, 1, 1, 0, 0, 0, 1};
        vecs[4]  = '{0, 1, 1, 0, 1, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 1, 0, 0, 0, 1, 0};
        vecs[7]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 1, 0, 0, 0, 1, 0};
        vecs[9]  = '{2, 1, 1, 0, 0, 1, 0, 0};
        vecs[10] = '{2, 0, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{2, 1, 1, 1, 0, 0, 0, 0};
        s2Ids = '{6'd1, 6'd2, 6'd5, 6'd6};

        // Reset values, with both requests pushing during reset
        idleInputs();
        rst = 1;
        mul_valid = 1;
        div_valid = 1;
        tick();
        settle();
        chk("rst mul_ready", mul_ready, 0);
        chk("rst div_ready", div_ready, 0);
        chk("rst issue_valid", issue_valid, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_is_lo", wb_is_lo, 0);
        chk("rst wb_is_div", wb_is_div, 0);
        chk("rst wb_rob_id", wb_rob_id, 0);
        chk("rst idle", idle, 1);

        // Single-cycle grant table
        for (int v = 0; v < 12; v++) begin
            doReset();
            if (vecs[v].pre == 1) begin
                mul_valid = 1;
                tick();
                idleInputs();
            end else if (vecs[v].pre == 2) begin
                div_valid = 1;
                tick();
                idleInputs();
            end
            mul_valid = vecs[v].mv;
            div_valid = vecs[v].dv;
            flush = vecs[v].fl;
            rst = vecs[v].rs;
            mul_hi_id = 6'd9;
            mul_lo_id = 6'd10;
            div_hi_id = 6'd11;
            div_lo_id = 6'd12;
            settle();
            chk($sformatf("vec%0d mul_ready", v), mul_ready, vecs[v].expMr);
            chk($sformatf("vec%0d div_ready", v), div_ready, vecs[v].expDr);
            chk($sformatf("vec%0d issue_valid", v), issue_valid, vecs[v].expMr | vecs[v].expDr);
            chk($sformatf("vec%0d issue_is_div", v), issue_is_div, vecs[v].expDr);
            chk($sformatf("vec%0d idle", v), idle, vecs[v].expIdle);
            tick();
            rst = 0;
        end

        // Scenario 1: single multiply
        doReset();
        for (int c = 0; c <= 18; c++) begin
            mul_valid = (c == 10);
            mul_hi_id = 6'd3;
            mul_lo_id = 6'd4;
            settle();
            if (c == 10) chk("s1 mul_ready@10", mul_ready, 1);
            if (c == 14) chk("s1 wb_valid@14", wb_valid, 0);
            if (c == 15) chkWb("s1 @15", 1, 0, 0, 3);
            if (c == 16) chkWb("s1 @16", 1, 1, 0, 4);
            if (c == 16) chk("s1 idle@16", idle, 0);
            if (c == 17) chk("s1 idle@17", idle, 1);
            tick();
        end

        // Scenario 2: back-to-back multiplies
        doReset();
        for (int c = 0; c <= 19; c++) begin
            mul_valid = (c >= 10 && c <= 13);
            mul_hi_id = (c == 10) ? 6'd1 : 6'd5;
            mul_lo_id = (c == 10) ? 6'd2 : 6'd6;
            settle();
            if (c >= 10 && c <= 13) chk($sformatf("s2 mul_ready@%0d", c), mul_ready, (c == 10 || c == 12));
            if (c >= 15 && c <= 18) chkWb($sformatf("s2 @%0d", c), 1, (c % 2 == 0), 0, s2Ids[c-15]);
            if (c == 14 || c == 19) chk($sformatf("s2 wb_valid@%0d", c), wb_valid, 0);
            tick();
        end

        // Scenario 3: simultaneous mul and div after reset
        doReset();
        for (int c = 0; c <= 23; c++) begin
            mul_valid = (c == 0);
            div_valid = (c <= 1);
            mul_hi_id = 6'd10;
            mul_lo_id = 6'd11;
            div_hi_id = 6'd20;
            div_lo_id = 6'd21;
            settle();
            if (c == 0) chk("s3 mul_ready@0", mul_ready, 1);
            if (c == 0) chk("s3 div_ready@0", div_ready, 0);
            if (c == 1) chk("s3 div_ready@1", div_ready, 1);
            if (c == 1) chk("s3 issue_is_div@1", issue_is_div, 1);
            if (c == 5) chkWb("s3 @5", 1, 0, 0, 10);
            if (c == 6) chkWb("s3 @6", 1, 1, 0, 11);
            if (c == 21) chkWb("s3 @21", 1, 0, 1, 20);
            if (c == 22) chkWb("s3 @22", 1, 1, 1, 21);
            if (c == 23) chk("s3 idle@23", idle, 1);
            tick();
        end

        // Scenario 4: multiply stalls behind a divide's slots
        doReset();
        for (int c = 0; c <= 24; c++) begin
            div_valid = (c == 0);
            mul_valid = (c >= 15 && c <= 17);
            div_hi_id = 6'd30;
            div_lo_id = 6'd31;
            mul_hi_id = 6'd40;
            mul_lo_id = 6'd41;
            settle();
            if (c == 0) chk("s4 div_ready@0", div_ready, 1);
            if (c >= 15 && c <= 17) chk($sformatf("s4 mul_ready@%0d", c), mul_ready, (c == 17));
            if (c == 20) chkWb("s4 @20", 1, 0, 1, 30);
            if (c == 21) chkWb("s4 @21", 1, 1, 1, 31);
            if (c == 22) chkWb("s4 @22", 1, 0, 0, 40);
            if (c == 23) chkWb("s4 @23", 1, 1, 0, 41);
            if (c == 24) chk("s4 wb_valid@24", wb_valid, 0);
            tick();
        end

        // Scenario 5: flush kills an in-flight multiply
        doReset();
        for (int c = 0; c <= 17; c++) begin
            mul_valid = (c == 10 || c == 13);
            flush = (c == 13);
            mul_hi_id = (c == 10) ? 6'd12 : 6'd14;
            mul_lo_id = (c == 10) ? 6'd13 : 6'd15;
            settle();
            if (c == 10) chk("s5 mul_ready@10", mul_ready, 1);
            if (c == 13) chk("s5 mul_ready@13", mul_ready, 0);
            if (c == 13) chk("s5 issue_valid@13", issue_valid, 0);
            if (c == 13) chk("s5 idle@13", idle, 0);
            if (c == 14) chk("s5 idle@14", idle, 1);
            if (c == 15 || c == 16) chk($sformatf("s5 wb_valid@%0d", c), wb_valid, 0);
            tick();
        end
        flush = 0;

        // Scenario 6: reset mid-operation restores mul-first priority
        doReset();
        for (int c = 0; c <= 22; c++) begin
            rst = (c == 5);
            div_valid = (c == 0 || c == 5 || c == 7 || c == 8);
            mul_valid = (c == 2 || c == 5 || c == 7);
            div_hi_id = (c == 0) ? 6'd50 : 6'd56;
            div_lo_id = (c == 0) ? 6'd51 : 6'd57;
            mul_hi_id = (c == 7) ? 6'd58 : 6'd52;
            mul_lo_id = (c == 7) ? 6'd59 : 6'd53;
            settle();
            if (c == 0) chk("s6 div_ready@0", div_ready, 1);
            if (c == 2) chk("s6 mul_ready@2", mul_ready, 1);
            if (c == 5) chk("s6 mul_ready@5", mul_ready, 0);
            if (c == 5) chk("s6 div_ready@5", div_ready, 0);
            if (c == 5) chk("s6 issue_valid@5", issue_valid, 0);
            if (c == 6) chk("s6 idle@6", idle, 1);
            if (c == 7) chk("s6 mul_ready@7", mul_ready, 1);
            if (c == 7) chk("s6 div_ready@7", div_ready, 0);
            if (c == 8) chk("s6 div_ready@8", div_ready, 1);
            if (c == 7 || c == 8 || c == 20 || c == 21) chk($sformatf("s6 wb_valid@%0d", c), wb_valid, 0);
            if (c == 12) chkWb("s6 @12", 1, 0, 0, 58);
            if (c == 13) chkWb("s6 @13", 1, 1, 0, 59);
            tick();
        end
        rst = 0;

        // Randomized run against a calendar of booked writeback cycles
        doReset();
        t = 0;
        lastWasMul = 0;
        sched.delete();
        for (int i = 0; i < 3000; i++) begin
            if (!mul_valid && $urandom_range(0, 9) < 4) begin
                mul_valid = 1;
                mul_hi_id = ROB_ID_W'($urandom_range(0, 63));
                mul_lo_id = ROB_ID_W'($urandom_range(0, 63));
            end
            if (!div_valid && $urandom_range(0, 9) < 2) begin
                div_valid = 1;
                div_hi_id = ROB_ID_W'($urandom_range(0, 63));
                div_lo_id = ROB_ID_W'($urandom_range(0, 63));
            end
            flush = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 199) == 0);
            settle();

            mFree = !sched.exists(t + MUL_LAT) && !sched.exists(t + MUL_LAT + 1);
            dFree = !sched.exists(t + DIV_LAT) && !sched.exists(t + DIV_LAT + 1);
            blocked = flush || rst;
            mAcc = !blocked && mul_valid && mFree && (!(div_valid && dFree) || !lastWasMul);
            dAcc = !blocked && div_valid && dFree && !mAcc;
            chk($sformatf("rnd%0d mul_ready", i), mul_ready, mAcc);
            chk($sformatf("rnd%0d div_ready", i), div_ready, dAcc);
            chk($sformatf("rnd%0d issue_valid", i), issue_valid, mAcc | dAcc);
            chk($sformatf("rnd%0d issue_is_div", i), issue_is_div, dAcc);
            chk($sformatf("rnd%0d idle", i), idle, sched.num() == 0);
            expWbV = sched.exists(t);
            if (expWbV) e = sched[t];
            else e = '{0, 0, 0};
            chkWb($sformatf("rnd%0d", i), expWbV, e.lo, e.isDiv, e.id);

            if (sched.exists(t)) sched.delete(t);
            if (blocked) sched.delete();
            if (rst) lastWasMul = 0;
            if (mAcc) begin
                sched[t + MUL_LAT] = '{0, 0, int'(mul_hi_id)};
                sched[t + MUL_LAT + 1] = '{1, 0, int'(mul_lo_id)};
                lastWasMul = 1;
            end
            if (dAcc) begin
                sched[t + DIV_LAT] = '{0, 1, int'(div_hi_id)};
                sched[t + DIV_LAT + 1] = '{1, 1, int'(div_lo_id)};
                lastWasMul = 0;
            end

            tick();
            if (mAcc) mul_valid = 0;
            if (dAcc) div_valid = 0;
            t++;
        end
        idleInputs();
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
